cpu_sequencer: RTL and testbench

Multi-cycle control unit for the 8-bit accumulator CPU. It steps the existing datapath (PC, IR, accumulator, ALU, instruction memory) through FETCH / DECODE / EXECUTE and drives its load and write strobes. It adds host run/step control, one PC breakpoint, a halt instruction, a zero-conditional jump, and saturating performance counters. It sits between the debug host interface and the datapath registers.

---
 rtl/cpu_ctrl_pkg.sv | 45 ++++
 rtl/cpu_sequencer_if.sv | 37 +++
 rtl/sat_counter.sv | 36 +++
 rtl/cpu_sequencer.sv | 160 ++++++++++++++++
 tb/tb_cpu_sequencer.sv | 314 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the accumulator CPU control unit.
// Contents: sequencer state enum, opcode constants, opcode class enum,
// halt-cause encoding, sequencing mode and the opcode-to-class decoder.
package cpu_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_HALTED  = 2'd0,
    ST_FETCH   = 2'd1,
    ST_DECODE  = 2'd2,
    ST_EXECUTE = 2'd3
  } state_e;

  localparam logic [3:0] OP_JMP = 4'b0100;
  localparam logic [3:0] OP_JZ  = 4'b0101;
  localparam logic [3:0] OP_HLT = 4'b1111;

  typedef enum logic [1:0] {
    CLS_ALU = 2'd0,
    CLS_JMP = 2'd1,
    CLS_JZ  = 2'd2,
    CLS_HLT = 2'd3
  } class_e;

  typedef enum logic [1:0] {
    CAUSE_NONE = 2'd0,
    CAUSE_HOST = 2'd1,
    CAUSE_HLT  = 2'd2,
    CAUSE_BP   = 2'd3
  } cause_e;

  typedef enum logic {
    MODE_RUN  = 1'b0,
    MODE_STEP = 1'b1
  } mode_e;

  function automatic class_e decode_class(input logic [3:0] op);
    case (op)
      OP_JMP:  return CLS_JMP;
      OP_JZ:   return CLS_JZ;
      OP_HLT:  return CLS_HLT;
      default: return CLS_ALU;
    endcase
  endfunction

endpackage

// File: rtl/cpu_sequencer_if.sv
// Host/datapath bundle for the CPU sequencer.
// master: debug host + datapath side (drives control inputs, pc, opcode,
//         acc_zero; receives strobes, status and counters).
// slave : the sequencer itself.
interface cpu_sequencer_if #(
  parameter int PC_W  = 8,
  parameter int CNT_W = 16
);
  logic             run;
  logic             step_req;
  logic             bp_en;
  logic [PC_W-1:0]  bp_addr;
  logic [PC_W-1:0]  pc;
  logic [3:0]       opcode;
  logic             acc_zero;
  logic             clr_counts;
  logic             ir_load;
  logic             pc_inc;
  logic             pc_load;
  logic             acc_we;
  logic             halted;
  logic [1:0]       halt_cause;
  logic [CNT_W-1:0] cycle_count;
  logic [CNT_W-1:0] instr_count;

  modport master (
    output run, step_req, bp_en, bp_addr, pc, opcode, acc_zero, clr_counts,
    input  ir_load, pc_inc, pc_load, acc_we, halted, halt_cause,
           cycle_count, instr_count
  );

  modport slave (
    input  run, step_req, bp_en, bp_addr, pc, opcode, acc_zero, clr_counts,
    output ir_load, pc_inc, pc_load, acc_we, halted, halt_cause,
           cycle_count, instr_count
  );
endinterface

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear.
// Ports: clk, reset_n (async active-low), inc (count enable),
//        clr (sync clear, wins over inc), count (current value).
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc && (count_q != '1)) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/cpu_sequencer.sv
// Multi-cycle FETCH/DECODE/EXECUTE control unit for the 8-bit accumulator
// CPU, with host run/step control, one PC breakpoint, HLT and JZ support,
// and saturating cycle/instruction counters.
// Ports: clk, reset_n (async active-low), bus (cpu_sequencer_if.slave):
//   inputs  run, step_req, bp_en, bp_addr, pc, opcode, acc_zero, clr_counts
//   outputs ir_load, pc_inc, pc_load, acc_we, halted, halt_cause,
//           cycle_count, instr_count
module cpu_sequencer
  import cpu_ctrl_pkg::*;
#(
  parameter int PC_W  = 8,
  parameter int CNT_W = 16
) (
  input  logic           clk,
  input  logic           reset_n,
  cpu_sequencer_if.slave bus
);

  state_e state_q, state_d;
  mode_e  mode_q, mode_d;
  logic   bp_skip_q, bp_skip_d;
  class_e cls_q, cls_d;
  logic   jz_take_q, jz_take_d;
  cause_e cause_q, cause_d;

  logic [PC_W-1:0] pc_w;
  logic [PC_W-1:0] bp_addr_w;
  logic            bp_hit;

  logic ir_load;
  logic pc_inc;
  logic pc_load;
  logic acc_we;

  assign pc_w      = bus.pc;
  assign bp_addr_w = bus.bp_addr;

  // bp_skip lets a resume at the breakpoint PC execute that instruction
  // instead of re-trapping immediately.
  assign bp_hit = bus.bp_en && (pc_w == bp_addr_w) && !bp_skip_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_HALTED;
      mode_q    <= MODE_RUN;
      bp_skip_q <= 1'b0;
      cls_q     <= CLS_ALU;
      jz_take_q <= 1'b0;
      cause_q   <= CAUSE_NONE;
    end else begin
      state_q   <= state_d;
      mode_q    <= mode_d;
      bp_skip_q <= bp_skip_d;
      cls_q     <= cls_d;
      jz_take_q <= jz_take_d;
      cause_q   <= cause_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    bp_skip_d = bp_skip_q;
    cls_d     = cls_q;
    jz_take_d = jz_take_q;
    cause_d   = cause_q;
    case (state_q)
      ST_HALTED: begin
        // run has priority; a simultaneous step_req is dropped.
        if (bus.run) begin
          state_d   = ST_FETCH;
          mode_d    = MODE_RUN;
          bp_skip_d = 1'b1;
        end else if (bus.step_req) begin
          state_d   = ST_FETCH;
          mode_d    = MODE_STEP;
          bp_skip_d = 1'b1;
        end
      end
      ST_FETCH: begin
        if (bp_hit) begin
          state_d = ST_HALTED;
          cause_d = CAUSE_BP;
        end else begin
          bp_skip_d = 1'b0;
          state_d   = ST_DECODE;
        end
      end
      ST_DECODE: begin
        // The JZ condition is frozen here so later acc_zero changes
        // cannot alter the branch decision.
        cls_d     = decode_class(bus.opcode);
        jz_take_d = bus.acc_zero;
        state_d   = ST_EXECUTE;
      end
      ST_EXECUTE: begin
        if (cls_q == CLS_HLT) begin
          state_d = ST_HALTED;
          cause_d = CAUSE_HLT;
        end else if ((mode_q == MODE_STEP) || !bus.run) begin
          state_d = ST_HALTED;
          cause_d = CAUSE_HOST;
        end else begin
          state_d = ST_FETCH;
        end
      end
      default: state_d = ST_HALTED;
    endcase
  end

  always_comb begin
    ir_load = 1'b0;
    pc_inc  = 1'b0;
    pc_load = 1'b0;
    acc_we  = 1'b0;
    case (state_q)
      ST_FETCH: ir_load = !bp_hit;
      ST_EXECUTE: begin
        case (cls_q)
          CLS_JMP: pc_load = 1'b1;
          CLS_JZ: begin
            if (jz_take_q) pc_load = 1'b1;
            else           pc_inc  = 1'b1;
          end
          CLS_HLT: ;
          default: begin
            acc_we = 1'b1;
            pc_inc = 1'b1;
          end
        endcase
      end
      default: ;
    endcase
  end

  assign bus.ir_load    = ir_load;
  assign bus.pc_inc     = pc_inc;
  assign bus.pc_load    = pc_load;
  assign bus.acc_we     = acc_we;
  assign bus.halted     = (state_q == ST_HALTED);
  assign bus.halt_cause = cause_q;

  sat_counter #(.CNT_W(CNT_W)) u_cycle_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .inc     (state_q != ST_HALTED),
    .clr     (bus.clr_counts),
    .count   (bus.cycle_count)
  );

  // HLT also retires, so every EXECUTE cycle counts.
  sat_counter #(.CNT_W(CNT_W)) u_instr_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .inc     (state_q == ST_EXECUTE),
    .clr     (bus.clr_counts),
    .count   (bus.instr_count)
  );

endmodule

// File: tb/tb_cpu_sequencer.sv
// Testbench for cpu_sequencer: a tiny datapath (PC, IR, instruction memory)
// driven by the DUT strobes, plus an instruction-level reference model of
// the sequencing rules, checked every cycle and at scenario end points.
module tb_cpu_sequencer;

  localparam int CMAX = 65535;

  logic clk;
  logic reset_n;

  cpu_sequencer_if #(.PC_W(8), .CNT_W(16)) bus ();

  cpu_sequencer #(.PC_W(8), .CNT_W(16)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Datapath stand-in
  logic [7:0] imem [256];
  logic [7:0] pc_r;
  logic [7:0] ir_r;
  int         n_irl;

  assign bus.pc     = pc_r;
  assign bus.opcode = ir_r[7:4];

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc_r  <= 8'h00;
      ir_r  <= 8'h00;
      n_irl <= 0;
    end else begin
      if (bus.ir_load) begin
        ir_r  <= imem[pc_r];
        n_irl <= n_irl + 1;
      end
      if (bus.pc_load)     pc_r <= {4'h0, ir_r[3:0]};
      else if (bus.pc_inc) pc_r <= pc_r + 8'd1;
    end
  end

  // Reference model: phase 0 = halted, 1..3 = position within an instruction
  typedef struct {
    int         phase;
    bit         step;
    bit         skip;
    bit         take;
    logic [3:0] op;
    logic [1:0] cause;
    int         cyc;
    int         ins;
  } mstate_t;

  mstate_t m_q;

  function automatic mstate_t model_reset();
    mstate_t s;
    s.phase = 0; s.step = 0; s.skip = 0; s.take = 0;
    s.op = 4'h0; s.cause = 2'd0; s.cyc = 0; s.ins = 0;
    return s;
  endfunction

  function automatic bit bp_trap(input mstate_t s);
    return (s.phase == 1) && bus.bp_en && (bus.pc == bus.bp_addr) && !s.skip;
  endfunction

  function automatic mstate_t model_next(input mstate_t s);
    mstate_t n = s;
    if (bus.clr_counts) begin
      n.cyc = 0;
      n.ins = 0;
    end else begin
      if (s.phase != 0 && s.cyc < CMAX) n.cyc = s.cyc + 1;
      if (s.phase == 3 && s.ins < CMAX) n.ins = s.ins + 1;
    end
    case (s.phase)
      0: begin
        if (bus.run)           begin n.phase = 1; n.step = 0; n.skip = 1; end
        else if (bus.step_req) begin n.phase = 1; n.step = 1; n.skip = 1; end
      end
      1: begin
        if (bp_trap(s)) begin n.phase = 0; n.cause = 2'd3; end
        else            begin n.phase = 2; n.skip = 0; end
      end
      2: begin
        n.op = bus.opcode;
        n.take = bus.acc_zero;
        n.phase = 3;
      end
      default: begin
        if (s.op == 4'hF)            begin n.phase = 0; n.cause = 2'd2; end
        else if (s.step || !bus.run) begin n.phase = 0; n.cause = 2'd1; end
        else                         n.phase = 1;
      end
    endcase
    return n;
  endfunction

  function automatic logic [6:0] m_expect(input mstate_t s);
    logic il, pi, pl, aw;
    il = 1'b0; pi = 1'b0; pl = 1'b0; aw = 1'b0;
    if (s.phase == 1 && !bp_trap(s)) il = 1'b1;
    if (s.phase == 3) begin
      if (s.op == 4'h4) pl = 1'b1;
      else if (s.op == 4'h5) begin
        if (s.take) pl = 1'b1;
        else        pi = 1'b1;
      end else if (s.op != 4'hF) begin
        aw = 1'b1;
        pi = 1'b1;
      end
    end
    return {il, pi, pl, aw, (s.phase == 0), s.cause};
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) m_q <= model_reset();
    else          m_q <= model_next(m_q);
  end

  // Checking
  int n_checks;
  int n_pass;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
  endtask

  function automatic logic [6:0] obs_outs();
    return {bus.ir_load, bus.pc_inc, bus.pc_load, bus.acc_we, bus.halted, bus.halt_cause};
  endfunction

  // One clock: compare against the model mid-cycle, return 2 ns after the edge.
  task automatic tick();
    @(negedge clk);
    if (reset_n) begin
      chk("outs", 64'(obs_outs()), 64'(m_expect(m_q)));
      chk("counts", 64'({bus.cycle_count, bus.instr_count}),
          64'((m_q.cyc << 16) | m_q.ins));
    end
    @(posedge clk);
    #2;
  endtask

  task automatic wait_halt(input int budget);
    int n;
    n = 0;
    while (!bus.halted && n < budget) begin
      tick();
      n++;
    end
    if (!bus.halted) chk("halt_timeout", 64'(0), 64'(1));
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    #1;
    reset_n = 1'b1;
  endtask

  task automatic fill(input logic [7:0] v);
    for (int i = 0; i < 256; i++) imem[i] = v;
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    reset_n  = 1'b0;
    bus.run = 1'b0; bus.step_req = 1'b0; bus.bp_en = 1'b0; bus.bp_addr = 8'h00;
    bus.acc_zero = 1'b0; bus.clr_counts = 1'b0;
    fill(8'h12);
    #1;
    chk("rst_outs", 64'(obs_outs()), 64'(7'b0000100));
    chk("rst_counts", 64'({bus.cycle_count, bus.instr_count}), 64'(0));
    @(posedge clk); #2;
    reset_n = 1'b1;

    // Straight-line ALU, ALU, HLT
    imem[0] = 8'h10; imem[1] = 8'h11; imem[2] = 8'hF0;
    bus.run = 1'b1;
    tick();
    wait_halt(50);
    bus.run = 1'b0;
    chk("hlt_cause", 64'(bus.halt_cause), 64'(2));
    chk("hlt_instr", 64'(bus.instr_count), 64'(3));
    chk("hlt_cycles", 64'(bus.cycle_count), 64'(9));
    chk("hlt_pc", 64'(pc_r), 64'(2));
    chk("hlt_irloads", 64'(n_irl), 64'(3));
    tick();

    // JMP loop, host drops run mid-instruction
    do_reset();
    fill(8'h40);
    bus.run = 1'b1;
    repeat (5) tick();
    bus.run = 1'b0;
    wait_halt(10);
    chk("host_cause", 64'(bus.halt_cause), 64'(1));
    chk("host_irloads", 64'(n_irl), 64'(2));
    tick();

    // Breakpoint at 2, then single step over it
    do_reset();
    fill(8'h12);
    bus.bp_en = 1'b1; bus.bp_addr = 8'h02;
    bus.run = 1'b1;
    tick();
    wait_halt(50);
    bus.run = 1'b0;
    chk("bp_cause", 64'(bus.halt_cause), 64'(3));
    chk("bp_pc", 64'(pc_r), 64'(2));
    chk("bp_irloads", 64'(n_irl), 64'(2));
    bus.step_req = 1'b1;
    tick();
    bus.step_req = 1'b0;
    wait_halt(10);
    chk("step_cause", 64'(bus.halt_cause), 64'(1));
    chk("step_pc", 64'(pc_r), 64'(3));
    chk("step_instr", 64'(bus.instr_count), 64'(3));
    bus.bp_en = 1'b0;

    // JZ taken / not taken, acc_zero flipped during EXECUTE
    do_reset();
    fill(8'h12);
    imem[0] = 8'h55; imem[5] = 8'h57;
    bus.acc_zero = 1'b1; bus.step_req = 1'b1;
    tick();
    bus.step_req = 1'b0;
    tick(); tick();
    bus.acc_zero = 1'b0;
    wait_halt(10);
    chk("jz_taken_pc", 64'(pc_r), 64'(5));
    bus.step_req = 1'b1;
    tick();
    bus.step_req = 1'b0;
    tick(); tick(); tick();
    bus.acc_zero = 1'b1;
    wait_halt(10);
    chk("jz_fall_pc", 64'(pc_r), 64'(6));
    bus.acc_zero = 1'b0;

    // run and step together, then step during run
    do_reset();
    fill(8'h40);
    bus.run = 1'b1; bus.step_req = 1'b1;
    tick();
    bus.step_req = 1'b0;
    repeat (10) tick();
    chk("run_wins", 64'(bus.halted), 64'(0));
    bus.step_req = 1'b1;
    tick();
    bus.step_req = 1'b0;
    repeat (6) tick();
    chk("step_in_run", 64'(bus.halted), 64'(0));
    bus.run = 1'b0;
    wait_halt(10);
    chk("run_stop_cause", 64'(bus.halt_cause), 64'(1));

    // Reset during DECODE
    do_reset();
    fill(8'h12);
    bus.run = 1'b1;
    tick(); tick();
    reset_n = 1'b0;
    #1;
    chk("midrst_outs", 64'(obs_outs()), 64'(7'b0000100));
    chk("midrst_counts", 64'({bus.cycle_count, bus.instr_count}), 64'(0));
    bus.run = 1'b0;
    reset_n = 1'b1;
    tick();

    // Randomized programs and host activity
    for (int r = 0; r < 4; r++) begin
      do_reset();
      for (int i = 0; i < 256; i++) imem[i] = 8'($urandom_range(0, 255));
      bus.bp_en   = 1'($urandom_range(0, 1));
      bus.bp_addr = 8'($urandom_range(0, 15));
      for (int c = 0; c < 400; c++) begin
        bus.run        = ($urandom_range(0, 9) < 7);
        bus.step_req   = ($urandom_range(0, 9) == 0);
        bus.acc_zero   = 1'($urandom_range(0, 1));
        bus.clr_counts = ($urandom_range(0, 31) == 0);
        tick();
      end
      bus.run = 1'b0; bus.step_req = 1'b0; bus.clr_counts = 1'b0;
      wait_halt(10);
    end
    bus.bp_en = 1'b0;

    // Counter saturation and clear
    do_reset();
    fill(8'h40);
    bus.run = 1'b1;
    repeat (65540) tick();
    chk("cyc_sat", 64'(bus.cycle_count), 64'(16'hFFFF));
    bus.clr_counts = 1'b1;
    tick();
    bus.clr_counts = 1'b0;
    chk("cyc_clr", 64'(bus.cycle_count), 64'(0));
    chk("ins_clr", 64'(bus.instr_count), 64'(0));
    bus.run = 1'b0;
    wait_halt(10);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
